// File: rtl/dbl_seq_89_pkg.sv
// Shared constants and types for the xDBL micro-sequencer over the 89-bit prime field.
// Holds the field constants, the wrapper instruction encoding, the sequencer
// state encoding, the wrapper command layout and the fixed doubling program.
package dbl_seq_89_pkg;

  localparam int W  = 89;
  localparam int AW = 7;

  // Field prime and its double, carried at W+1 bits so the redundant sum fits.
  localparam logic [W:0] P  = 90'd501974515280983173562892287;
  localparam logic [W:0] P2 = 90'd1003949030561966347125784574;

  // Wrapper instruction codes.
  typedef enum logic [2:0] {
    INS_IDLE = 3'd0,
    INS_LOAD = 3'd1,
    INS_COPY = 3'd2,
    INS_ADD  = 3'd3,
    INS_SUB  = 3'd4,
    INS_MUL  = 3'd5
  } ins_e;

  // Sequencer phases.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_EXEC = 3'd2,
    ST_READ = 3'd3,
    ST_CAP  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Wrapper command word: {INS, rd_addr_1, rd_addr_2, wr_addr}, 24 bits.
  typedef struct packed {
    ins_e          ins;
    logic [AW-1:0] rd1;
    logic [AW-1:0] rd2;
    logic [AW-1:0] wr;
  } cmd_t;

  localparam int         PROG_LEN  = 10;
  localparam logic [3:0] PROG_LAST = 4'd9;
  localparam logic [3:0] LOAD_LAST = 4'd3;

  // Register-file slots holding the final X and Z after the program runs.
  localparam logic [AW-1:0] OUT_X_ADDR = 7'd6;
  localparam logic [AW-1:0] OUT_Z_ADDR = 7'd7;

  // xDBL program. Slots 0..3 hold X, Z, A, C on entry; 4, 5, 7 are scratch.
  //   r4 = X-Z, r5 = X+Z, r4 = r4^2, r5 = r5^2, r7 = C*r4, r6 = r7*r5 (X out),
  //   r5 = r5-r4, r4 = A*r5, r7 = r7+r4, r7 = r7*r5 (Z out)
  localparam cmd_t PROG_ROM [PROG_LEN] = '{
    '{INS_SUB, 7'd0, 7'd1, 7'd4},
    '{INS_ADD, 7'd0, 7'd1, 7'd5},
    '{INS_MUL, 7'd4, 7'd4, 7'd4},
    '{INS_MUL, 7'd5, 7'd5, 7'd5},
    '{INS_MUL, 7'd3, 7'd4, 7'd7},
    '{INS_MUL, 7'd7, 7'd5, 7'd6},
    '{INS_SUB, 7'd5, 7'd4, 7'd5},
    '{INS_MUL, 7'd2, 7'd5, 7'd4},
    '{INS_ADD, 7'd7, 7'd4, 7'd7},
    '{INS_MUL, 7'd7, 7'd5, 7'd7}
  };

endpackage

// File: rtl/mod_reduce_89.sv
// Reduces a redundant sum s = d1 + d2 (s < 3p) to its canonical value in [0, p).
// Two conditional subtractions: 2p first, then p.
// Build option REDUCE_REG_EN inserts a register between the two steps,
// adding one cycle of latency.
module mod_reduce_89
  import dbl_seq_89_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [W:0]   sum,
  output logic [W-1:0] result
);

  logic [W:0] stage1;
  logic [W:0] stage2_in;
  logic [W:0] stage2;

  // First step: fold anything at or above 2p down into [0, 2p).
  always_comb begin
    stage1 = (sum >= P2) ? (sum - P2) : sum;
  end

`ifdef REDUCE_REG_EN
  logic [W:0] stage1_reg;

  // Pipeline register between the 2p and p steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_reg <= '0;
    end else begin
      stage1_reg <= stage1;
    end
  end

  assign stage2_in = stage1_reg;
`else
  // Purely combinational build: clock and reset are not needed here.
  logic unused_clk_rst;
  assign unused_clk_rst = clk | rst;
  assign stage2_in      = stage1;
`endif

  // Second step: fold [p, 2p) down into [0, p).
  always_comb begin
    stage2 = (stage2_in >= P) ? (stage2_in - P) : stage2_in;
  end

  // The canonical value is below p < 2^89, so the top bit is always zero.
  logic unused_stage2_msb;
  assign unused_stage2_msb = stage2[W];
  assign result            = stage2[W-1:0];

endmodule

// File: rtl/dbl_sequencer_89.sv
// Micro-sequencer driving cryptoprocessor_wrapper_89 through one Montgomery
// x-only doubling xDBL(X:Z) with curve constants (A:C).
// Flow: IDLE -> LOAD(4) -> EXEC(10) -> READ(2) -> CAP -> DONE -> IDLE.
// Build option REDUCE_REG_EN registers the result reduction; CAP then takes
// two cycles and done arrives one cycle later.
module dbl_sequencer_89
  import dbl_seq_89_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] z_in,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] c_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] x_out,
  output logic [W-1:0] z_out,
  output logic         cp_get_output,
  output logic         cp_data_en,
  output logic         cp_ins_in,
  output logic [23:0]  cp_command,
  output logic [W-1:0] cp_din_1,
  output logic [W-1:0] cp_din_2,
  input  logic [W-1:0] cp_dout_1,
  input  logic [W-1:0] cp_dout_2
);

  state_e       state_reg;
  logic [3:0]   step_reg;
  logic [3:0]   step_inc;
  logic [W-1:0] op_reg [4];
  cmd_t         cmd_reg;
  logic         busy_reg;
  logic         done_reg;
  logic         get_output_reg;
  logic         data_en_reg;
  logic         ins_in_reg;
  logic [W-1:0] din_1_reg;
  logic [W-1:0] x_hold_reg;
  logic [W-1:0] x_out_reg;
  logic [W-1:0] z_out_reg;

  logic [W:0]   dout_sum;
  logic [W-1:0] red_val;
  logic         cap_x;
  logic         cap_z;

  assign step_inc = step_reg + 4'd1;

  // Redundant pair summed at W+1 bits; both halves are below 2^89, so s < 3p.
  assign dout_sum = {1'b0, cp_dout_1} + {1'b0, cp_dout_2};

  mod_reduce_89 u_reduce (
    .clk    (clk),
    .rst    (rst),
    .sum    (dout_sum),
    .result (red_val)
  );

  // The wrapper answers one cycle after each read request. X is requested in
  // READ step 0, Z in READ step 1; the reduced value appears one cycle later,
  // or two when the reduction is registered.
`ifdef REDUCE_REG_EN
  localparam logic [3:0] CAP_LAST = 4'd1;
  assign cap_x = (state_reg == ST_CAP) && (step_reg == 4'd0);
`else
  localparam logic [3:0] CAP_LAST = 4'd0;
  assign cap_x = (state_reg == ST_READ) && (step_reg == 4'd1);
`endif
  assign cap_z = (state_reg == ST_CAP) && (step_reg == CAP_LAST);

  // Sequencer FSM; every wrapper control is registered so it changes on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      step_reg       <= '0;
      for (int i = 0; i < 4; i++) begin
        op_reg[i] <= '0;
      end
      cmd_reg        <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      get_output_reg <= 1'b0;
      data_en_reg    <= 1'b0;
      ins_in_reg     <= 1'b0;
      din_1_reg      <= '0;
      x_hold_reg     <= '0;
      x_out_reg      <= '0;
      z_out_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      if (cap_x) begin
        x_hold_reg <= red_val;
      end

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            op_reg[0]   <= x_in;
            op_reg[1]   <= z_in;
            op_reg[2]   <= a_in;
            op_reg[3]   <= c_in;
            busy_reg    <= 1'b1;
            state_reg   <= ST_LOAD;
            step_reg    <= '0;
            data_en_reg <= 1'b1;
            ins_in_reg  <= 1'b1;
            cmd_reg     <= '{ins: INS_LOAD, rd1: '0, rd2: '0, wr: '0};
            din_1_reg   <= x_in;
          end
        end

        ST_LOAD: begin
          if (step_reg == LOAD_LAST) begin
            state_reg   <= ST_EXEC;
            step_reg    <= '0;
            data_en_reg <= 1'b0;
            cmd_reg     <= PROG_ROM[0];
            din_1_reg   <= '0;
          end else begin
            step_reg  <= step_inc;
            cmd_reg   <= '{ins: INS_LOAD, rd1: '0, rd2: '0, wr: AW'(step_inc)};
            din_1_reg <= op_reg[step_inc[1:0]];
          end
        end

        ST_EXEC: begin
          if (step_reg == PROG_LAST) begin
            state_reg      <= ST_READ;
            step_reg       <= '0;
            ins_in_reg     <= 1'b0;
            get_output_reg <= 1'b1;
            cmd_reg        <= '{ins: INS_IDLE, rd1: OUT_X_ADDR, rd2: '0, wr: '0};
          end else begin
            step_reg <= step_inc;
            cmd_reg  <= PROG_ROM[step_inc];
          end
        end

        ST_READ: begin
          if (step_reg == 4'd0) begin
            step_reg    <= 4'd1;
            cmd_reg.rd1 <= OUT_Z_ADDR;
          end else begin
            state_reg      <= ST_CAP;
            step_reg       <= '0;
            get_output_reg <= 1'b0;
            cmd_reg        <= '0;
          end
        end

        ST_CAP: begin
          if (cap_z) begin
            x_out_reg <= x_hold_reg;
            z_out_reg <= red_val;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_DONE;
            step_reg  <= '0;
          end else begin
            step_reg <= step_inc;
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign x_out         = x_out_reg;
  assign z_out         = z_out_reg;
  assign cp_get_output = get_output_reg;
  assign cp_data_en    = data_en_reg;
  assign cp_ins_in     = ins_in_reg;
  assign cp_command    = cmd_reg;
  assign cp_din_1      = din_1_reg;
  assign cp_din_2      = '0;

endmodule

// File: tb/tb_dbl_sequencer_89.sv
// Testbench for dbl_sequencer_89: behavioural wrapper model (or fixed-pair stub),
// scoreboard of expected results checked on each done pulse.
module tb_dbl_sequencer_89;

  localparam logic [89:0] PRIME = 90'd501974515280983173562892287;
  localparam logic [88:0] R_OFF = 89'd123456789012345678901234567;
`ifdef REDUCE_REG_EN
  localparam int LAT = 19;
`else
  localparam int LAT = 18;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [88:0] x_in, z_in, a_in, c_in;
  logic        busy, done;
  logic [88:0] x_out, z_out;
  logic        cp_get_output, cp_data_en, cp_ins_in;
  logic [23:0] cp_command;
  logic [88:0] cp_din_1, cp_din_2;
  logic [88:0] cp_dout_1, cp_dout_2;

  dbl_sequencer_89 dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .x_in          (x_in),
    .z_in          (z_in),
    .a_in          (a_in),
    .c_in          (c_in),
    .busy          (busy),
    .done          (done),
    .x_out         (x_out),
    .z_out         (z_out),
    .cp_get_output (cp_get_output),
    .cp_data_en    (cp_data_en),
    .cp_ins_in     (cp_ins_in),
    .cp_command    (cp_command),
    .cp_din_1      (cp_din_1),
    .cp_din_2      (cp_din_2),
    .cp_dout_1     (cp_dout_1),
    .cp_dout_2     (cp_dout_2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    logic [88:0] x;
    logic [88:0] z;
    int          acc;
  } exp_t;
  exp_t sb[$];

  function automatic void check(string name, logic [89:0] act, logic [89:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Field arithmetic for the wrapper model and golden xDBL.
  function automatic logic [88:0] addm(input logic [88:0] a, input logic [88:0] b);
    logic [89:0] s;
    s = {1'b0, a} + {1'b0, b};
    return 89'(s % PRIME);
  endfunction

  function automatic logic [88:0] subm(input logic [88:0] a, input logic [88:0] b);
    logic [89:0] s;
    s = {1'b0, a} + PRIME - {1'b0, b};
    return 89'(s % PRIME);
  endfunction

  function automatic logic [88:0] mulm(input logic [88:0] a, input logic [88:0] b);
    logic [177:0] t;
    logic [177:0] m;
    t = {89'd0, a} * {89'd0, b};
    m = {88'd0, PRIME};
    return 89'(t % m);
  endfunction

  // Golden xDBL: X' = C*(X-Z)^2*(X+Z)^2, Z' = E*(C*(X-Z)^2 + A*E), E = (X+Z)^2-(X-Z)^2.
  task automatic xdbl(input logic [88:0] x, z, a, c, output logic [88:0] ox, oz);
    logic [88:0] aa, bb, cbb, e;
    aa  = mulm(addm(x, z), addm(x, z));
    bb  = mulm(subm(x, z), subm(x, z));
    cbb = mulm(c, bb);
    e   = subm(aa, bb);
    ox  = mulm(cbb, aa);
    oz  = mulm(e, addm(cbb, mulm(a, e)));
  endtask

  // Wrapper model: executes commands, answers reads one cycle later.
  logic [88:0] rf [128];
  logic        stub_mode;
  logic [88:0] stub_x1, stub_x2, stub_z1, stub_z2;
  wire  [2:0]  m_ins = cp_command[23:21];
  wire  [6:0]  m_rd1 = cp_command[20:14];
  wire  [6:0]  m_rd2 = cp_command[13:7];
  wire  [6:0]  m_wr  = cp_command[6:0];

  initial begin
    for (int i = 0; i < 128; i++) rf[i] = '0;
    cp_dout_1 = '0;
    cp_dout_2 = '0;
  end

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (cp_ins_in) begin
      case (m_ins)
        3'd1: if (cp_data_en) rf[m_wr] <= addm(cp_din_1, cp_din_2);
        3'd2: rf[m_wr] <= rf[m_rd1];
        3'd3: rf[m_wr] <= addm(rf[m_rd1], rf[m_rd2]);
        3'd4: rf[m_wr] <= subm(rf[m_rd1], rf[m_rd2]);
        3'd5: rf[m_wr] <= mulm(rf[m_rd1], rf[m_rd2]);
        default: ;
      endcase
    end
    if (cp_get_output) begin
      if (stub_mode) begin
        cp_dout_1 <= (m_rd1 == 7'd6) ? stub_x1 : stub_z1;
        cp_dout_2 <= (m_rd1 == 7'd6) ? stub_x2 : stub_z2;
      end else begin
        cp_dout_1 <= subm(rf[m_rd1], R_OFF);
        cp_dout_2 <= R_OFF;
      end
    end
  end

  // Result monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (cp_data_en) check("din_2_zero", {1'b0, cp_din_2}, 90'd0);
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done with empty scoreboard, expected no done");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("x_out", {1'b0, x_out}, {1'b0, e.x});
          check("z_out", {1'b0, z_out}, {1'b0, e.z});
          check("latency", 90'(edge_cnt - e.acc), 90'(LAT));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [88:0] x, z, a, c, ex, ez);
    exp_t e;
    x_in = x; z_in = z; a_in = a; c_in = c;
    start = 1'b1;
    e.x = ex; e.z = ez; e.acc = edge_cnt;
    sb.push_back(e);
    tick(1);
    start = 1'b0;
    check("busy_after_start", {89'd0, busy}, 90'd1);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      tick(1);
      n++;
    end
    check("done_seen", {89'd0, done}, 90'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    {89'd0, busy}, 90'd0);
    check({tag, "_done"},    {89'd0, done}, 90'd0);
    check({tag, "_x_out"},   {1'b0, x_out}, 90'd0);
    check({tag, "_z_out"},   {1'b0, z_out}, 90'd0);
    check({tag, "_get_out"}, {89'd0, cp_get_output}, 90'd0);
    check({tag, "_data_en"}, {89'd0, cp_data_en}, 90'd0);
    check({tag, "_ins_in"},  {89'd0, cp_ins_in}, 90'd0);
    check({tag, "_command"}, {66'd0, cp_command}, 90'd0);
    check({tag, "_din_1"},   {1'b0, cp_din_1}, 90'd0);
  endtask

  typedef struct {
    logic [88:0] x, z, a, c;
    logic [88:0] ex, ez;
  } run_vec_t;

  typedef struct {
    logic [88:0] dx1, dx2, dz1, dz2;
    logic [88:0] ex, ez;
  } stub_vec_t;

  run_vec_t  rv [4];
  stub_vec_t sv [4];

  initial begin
    logic [88:0] p89, all1, ox, oz;
    logic [88:0] pair1 [4];
    logic [88:0] pair2 [4];
    logic [88:0] pexp  [4];
    logic [89:0] big;
    int d0;

    p89  = PRIME[88:0];
    all1 = '1;
    big  = ({1'b0, all1} + {1'b0, all1}) % PRIME;

    // Real-wrapper vectors; (1,1,8,4) is worked out by hand: X' = 0, Z' = 128.
    rv[0] = '{89'd37002296351524533193411810, 89'd34343669167373110674336784,
              89'd8, 89'd4, '0, '0};
    rv[1] = '{89'd1, 89'd1, 89'd8, 89'd4, 89'd0, 89'd128};
    rv[2] = '{p89 - 89'd1, 89'd2, 89'd3, 89'd5, '0, '0};
    rv[3] = '{89'd0, 89'd1, p89 - 89'd7, 89'd1234567, '0, '0};
    for (int i = 0; i < 4; i++) begin
      if (i != 1) begin
        xdbl(rv[i].x, rv[i].z, rv[i].a, rv[i].c, ox, oz);
        rv[i].ex = ox;
        rv[i].ez = oz;
      end
    end

    // Stub pairs: (p,0)->0, (p-1,0)->p-1, (2^89-1,2^89-1)->(2^90-2) mod p, (p,p+5)->5.
    pair1[0] = p89;         pair2[0] = 89'd0;         pexp[0] = 89'd0;
    pair1[1] = p89 - 89'd1; pair2[1] = 89'd0;         pexp[1] = p89 - 89'd1;
    pair1[2] = all1;        pair2[2] = all1;          pexp[2] = big[88:0];
    pair1[3] = p89;         pair2[3] = p89 + 89'd5;   pexp[3] = 89'd5;
    for (int i = 0; i < 4; i++) begin
      sv[i] = '{pair1[i], pair2[i], pair1[(i + 1) % 4], pair2[(i + 1) % 4],
                pexp[i], pexp[(i + 1) % 4]};
    end

    rst = 1'b1; start = 1'b0; stub_mode = 1'b0;
    x_in = '0; z_in = '0; a_in = '0; c_in = '0;
    stub_x1 = '0; stub_x2 = '0; stub_z1 = '0; stub_z2 = '0;
    tick(3);
    check_idle("reset");
    rst = 1'b0;
    tick(1);

    // Real-wrapper runs from the table.
    for (int i = 0; i < 4; i++) begin
      launch(rv[i].x, rv[i].z, rv[i].a, rv[i].c, rv[i].ex, rv[i].ez);
      wait_done(40);
      tick(1);
      check("done_pulse", {89'd0, done}, 90'd0);
      check("busy_after_done", {89'd0, busy}, 90'd0);
      $display("[TB] run %0d x=%0d z=%0d -> x_out=%0d z_out=%0d", i, rv[i].x, rv[i].z, x_out, z_out);
    end

    // Start re-pulsed at cycles 3 and 10 is ignored.
    d0 = done_cnt;
    launch(rv[0].x, rv[0].z, rv[0].a, rv[0].c, rv[0].ex, rv[0].ez);
    tick(2);
    x_in = 89'd77; start = 1'b1; tick(1); start = 1'b0;
    tick(6);
    z_in = 89'd99; start = 1'b1; tick(1); start = 1'b0;
    wait_done(40);
    tick(25);
    check("repulse_one_done", 90'(done_cnt - d0), 90'd1);
    $display("[TB] repulse run: dones=%0d x_out=%0d z_out=%0d", done_cnt - d0, x_out, z_out);

    // Reset mid-EXEC at cycle 9.
    d0 = done_cnt;
    launch(rv[0].x, rv[0].z, rv[0].a, rv[0].c, rv[0].ex, rv[0].ez);
    tick(8);
    rst = 1'b1;
    tick(1);
    check_idle("midrst");
    rst = 1'b0;
    sb.delete();
    tick(25);
    check("midrst_no_done", 90'(done_cnt - d0), 90'd0);
    launch(rv[2].x, rv[2].z, rv[2].a, rv[2].c, rv[2].ex, rv[2].ez);
    wait_done(40);
    tick(1);
    $display("[TB] after reset run: x_out=%0d z_out=%0d", x_out, z_out);

    // Back-to-back: start in done cycle ignored, start one cycle later accepted.
    launch(rv[0].x, rv[0].z, rv[0].a, rv[0].c, rv[0].ex, rv[0].ez);
    wait_done(40);
    x_in = 89'd5; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("start_in_done_ignored", {89'd0, busy}, 90'd0);
    launch(rv[1].x, rv[1].z, rv[1].a, rv[1].c, rv[1].ex, rv[1].ez);
    tick(3);
    check("x_out_held", {1'b0, x_out}, {1'b0, rv[0].ex});
    wait_done(40);
    tick(1);
    $display("[TB] back-to-back second run: x_out=%0d z_out=%0d", x_out, z_out);

    // Stub wrapper pairs exercise the reduction boundaries.
    stub_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stub_x1 = sv[i].dx1; stub_x2 = sv[i].dx2;
      stub_z1 = sv[i].dz1; stub_z2 = sv[i].dz2;
      launch(89'd1, 89'd2, 89'd3, 89'd4, sv[i].ex, sv[i].ez);
      wait_done(40);
      tick(1);
      $display("[TB] stub %0d: x_out=%0d z_out=%0d", i, x_out, z_out);
    end
    stub_mode = 1'b0;

    tick(2);
    check("scoreboard_empty", 90'(sb.size()), 90'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
